// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences PC, memory, IR, register
// file and ALU one step per cycle, stalling on the unified memory's req/ready handshake.
module multicycle_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [6:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             adr_src_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             reg_write_o,
  output logic [1:0]       result_src_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             illegal_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // 5-bit encoding leaves spare codes; they all fall back to FETCH.
  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_JALR, S_JALRWB,
    S_LUI, S_AUIPC, S_HALT
  } state_e;

  typedef struct packed {
    logic       req;
    logic       we;
    logic       adr;
    logic       pcu;
    logic       branch;
    logic       regw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] op;
    logic       hlt;
  } ctl_t;

  state_e           state_q, state_d;
  ctl_t             ctl_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  function automatic ctl_t ctl_of(input state_e s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.req = 1'b1; c.sb = 2'b10; c.res = 2'b10; end
      S_DECODE:   begin c.sa = 2'b01; c.sb = 2'b01; end
      S_MEMADR:   begin c.sa = 2'b10; c.sb = 2'b01; end
      S_MEMREAD:  begin c.req = 1'b1; c.adr = 1'b1; end
      S_MEMWB:    begin c.res = 2'b01; c.regw = 1'b1; end
      S_MEMWRITE: begin c.req = 1'b1; c.adr = 1'b1; c.we = 1'b1; end
      S_EXECR:    begin c.sa = 2'b10; c.sb = 2'b00; c.op = 2'b10; end
      S_EXECI:    begin c.sa = 2'b10; c.sb = 2'b01; c.op = 2'b10; end
      S_ALUWB:    begin c.res = 2'b00; c.regw = 1'b1; end
      S_BEQ:      begin c.sa = 2'b10; c.op = 2'b01; c.branch = 1'b1; end
      S_JAL:      begin c.sa = 2'b01; c.sb = 2'b10; c.pcu = 1'b1; end
      S_JALR:     begin c.sa = 2'b10; c.sb = 2'b01; c.res = 2'b10; c.pcu = 1'b1; end
      S_JALRWB:   begin c.sa = 2'b01; c.sb = 2'b10; c.res = 2'b10; c.regw = 1'b1; end
      S_LUI:      begin c.sa = 2'b11; c.sb = 2'b01; end
      S_HALT:     c.hlt = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic logic op_known(input logic [6:0] op);
    return op inside {OP_L, OP_S, OP_R, OP_I, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_L, OP_S: state_d = S_MEMADR;
          OP_R:       state_d = S_EXECR;
          OP_I:       state_d = S_EXECI;
          OP_B:       state_d = S_BEQ;
          OP_JAL:     state_d = S_JAL;
          OP_JALR:    state_d = S_JALR;
          OP_LUI:     state_d = S_LUI;
          OP_AUIPC:   state_d = S_AUIPC;
          default:    state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode_i == OP_L) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready_i ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready_i ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRWB;
      S_JALRWB:   state_d = S_FETCH;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Only the final step of a real instruction retires; illegal-opcode and
  // spare-encoding recovery paths into FETCH do not count.
  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ, S_JALRWB});

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      ctl_q     <= ctl_of(S_FETCH);
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_of(state_d);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign mem_req_o    = ctl_q.req;
  assign mem_we_o     = ctl_q.we;
  assign adr_src_o    = ctl_q.adr;
  assign reg_write_o  = ctl_q.regw;
  assign result_src_o = ctl_q.res;
  assign alu_src_a_o  = ctl_q.sa;
  assign alu_src_b_o  = ctl_q.sb;
  assign alu_op_o     = ctl_q.op;
  assign halted_o     = ctl_q.hlt;
  assign instret_o    = instret_q;

  assign ir_write_o = (state_q == S_FETCH) && mem_ready_i;
  assign pc_write_o = ir_write_o | ctl_q.pcu | (ctl_q.branch & zero_i);
  assign illegal_o  = (state_q == S_DECODE) && !op_known(opcode_i);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes hand-written per-cycle
// control vectors, a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       req, we, adr, irw, pcw, regw;
    logic [1:0] res, sa, sb, op;
    logic       ill, hlt;
  } ctl_t;

  typedef struct packed {
    logic       sel;
    ctl_t       c;
    logic [3:0] cnt;
  } ent_t;

  localparam logic [6:0] OP_L = 7'b0000011, OP_S = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  //                                 req we adr irw pcw regw | res  sa    sb    op   | ill hlt
  localparam ctl_t E_FETCH0  = ctl_t'({6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00});
  localparam ctl_t E_FETCH1  = ctl_t'({6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00});
  localparam ctl_t E_DECODE  = ctl_t'({6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00});
  localparam ctl_t E_DECILL  = ctl_t'({6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10});
  localparam ctl_t E_MEMADR  = ctl_t'({6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00});
  localparam ctl_t E_MEMRD   = ctl_t'({6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
  localparam ctl_t E_MEMWB   = ctl_t'({6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00});
  localparam ctl_t E_MEMWR   = ctl_t'({6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
  localparam ctl_t E_EXECR   = ctl_t'({6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00});
  localparam ctl_t E_EXECI   = ctl_t'({6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00});
  localparam ctl_t E_ALUWB   = ctl_t'({6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
  localparam ctl_t E_BEQ1    = ctl_t'({6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00});
  localparam ctl_t E_BEQ0    = ctl_t'({6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00});
  localparam ctl_t E_JAL     = ctl_t'({6'b000010, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00});
  localparam ctl_t E_JALR    = ctl_t'({6'b000010, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00});
  localparam ctl_t E_JALRWB  = ctl_t'({6'b000001, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00});
  localparam ctl_t E_AUIPC   = ctl_t'(16'h0000);
  localparam ctl_t E_LUI     = ctl_t'({6'b000000, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00});
  localparam ctl_t E_HALT    = ctl_t'(16'h0001);

  logic       clk = 1'b0;
  logic       rst_ni, rst_h_ni;
  logic [6:0] opcode;
  logic       zero, ready;

  logic       m_req, m_we, m_adr, m_irw, m_pcw, m_regw, m_ill, m_hlt;
  logic [1:0] m_res, m_sa, m_sb, m_op;
  logic [3:0] m_cnt;
  logic       h_req, h_we, h_adr, h_irw, h_pcw, h_regw, h_ill, h_hlt;
  logic [1:0] h_res, h_sa, h_sb, h_op;
  logic [3:0] h_cnt;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(4), .ILLEGAL_HALT(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(ready),
    .mem_req_o(m_req), .mem_we_o(m_we), .adr_src_o(m_adr), .ir_write_o(m_irw),
    .pc_write_o(m_pcw), .reg_write_o(m_regw), .result_src_o(m_res), .alu_src_a_o(m_sa),
    .alu_src_b_o(m_sb), .alu_op_o(m_op), .illegal_o(m_ill), .halted_o(m_hlt),
    .instret_o(m_cnt)
  );

  multicycle_ctrl #(.CNT_W(4), .ILLEGAL_HALT(1'b1)) dut_h (
    .clk_i(clk), .rst_ni(rst_h_ni), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(ready),
    .mem_req_o(h_req), .mem_we_o(h_we), .adr_src_o(h_adr), .ir_write_o(h_irw),
    .pc_write_o(h_pcw), .reg_write_o(h_regw), .result_src_o(h_res), .alu_src_a_o(h_sa),
    .alu_src_b_o(h_sb), .alu_op_o(h_op), .illegal_o(h_ill), .halted_o(h_hlt),
    .instret_o(h_cnt)
  );

  ent_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       done  = 1'b0;
  logic       chk_h = 1'b0;
  logic [3:0] ec    = 4'd0;

  task automatic drive(input logic [6:0] opc, input logic z, input logic rdy);
    opcode = opc; zero = z; ready = rdy;
  endtask

  task automatic push(input ctl_t e);
    ent_t x;
    x.sel = chk_h; x.c = e; x.cnt = ec;
    q.push_back(x);
  endtask

  task automatic cyc(input ctl_t e, input logic [6:0] opc, input logic z, input logic rdy);
    @(posedge clk); #1;
    drive(opc, z, rdy);
    push(e);
  endtask

  task automatic fetch();
    cyc(E_FETCH1, 7'h00, 1'b0, 1'b1);
  endtask

  task automatic alu_ins(input logic [6:0] opc, input ctl_t ex);
    fetch();
    cyc(E_DECODE, opc, 1'b0, 1'b1);
    cyc(ex, opc, 1'b0, 1'b1);
    cyc(E_ALUWB, opc, 1'b0, 1'b1);
    ec++;
  endtask

  task automatic sw_ins(input int waits);
    fetch();
    cyc(E_DECODE, OP_S, 1'b0, 1'b0);
    cyc(E_MEMADR, OP_S, 1'b0, 1'b0);
    for (int w = 0; w < waits; w++) cyc(E_MEMWR, OP_S, 1'b0, 1'b0);
    cyc(E_MEMWR, OP_S, 1'b0, 1'b1);
    ec++;
  endtask

  always @(negedge clk) begin
    ent_t       e;
    ctl_t       act;
    logic [3:0] cnt;
    if (q.size() != 0) begin
      e   = q.pop_front();
      act = e.sel ? {h_req, h_we, h_adr, h_irw, h_pcw, h_regw, h_res, h_sa, h_sb, h_op, h_ill, h_hlt}
                  : {m_req, m_we, m_adr, m_irw, m_pcw, m_regw, m_res, m_sa, m_sb, m_op, m_ill, m_hlt};
      cnt = e.sel ? h_cnt : m_cnt;
      n_vec++;
      if (act !== e.c) begin
        n_err++;
        $display("FAIL ctl vec %0d dut%0s @%0t: got %b want %b (req we adr irw pcw regw res sa sb op ill hlt)",
                 n_vec, e.sel ? "_h" : "", $time, act, e.c);
      end
      n_vec++;
      if (cnt !== e.cnt) begin
        n_err++;
        $display("FAIL instret vec %0d dut%0s @%0t: got %0d want %0d",
                 n_vec, e.sel ? "_h" : "", $time, cnt, e.cnt);
      end
    end else if (done) begin
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; rst_h_ni = 1'b0;
    drive(7'h00, 1'b0, 1'b0);
    cyc(E_FETCH0, 7'h00, 1'b0, 1'b0);
    @(negedge clk); #1 rst_ni = 1'b1;

    // lw with three wait cycles in MEMREAD
    fetch();
    cyc(E_DECODE, OP_L, 1'b0, 1'b0);
    cyc(E_MEMADR, OP_L, 1'b0, 1'b0);
    repeat (3) cyc(E_MEMRD, OP_L, 1'b0, 1'b0);
    cyc(E_MEMRD, OP_L, 1'b0, 1'b1);
    cyc(E_MEMWB, OP_L, 1'b0, 1'b1);
    ec++;

    // async reset while a load is waiting on memory
    fetch();
    cyc(E_DECODE, OP_L, 1'b0, 1'b0);
    cyc(E_MEMADR, OP_L, 1'b0, 1'b0);
    cyc(E_MEMRD, OP_L, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(OP_L, 1'b0, 1'b0);
    rst_ni = 1'b0; ec = 4'd0;
    push(E_FETCH0);
    cyc(E_FETCH0, OP_L, 1'b0, 1'b0);
    @(negedge clk); #1 rst_ni = 1'b1;

    alu_ins(OP_JAL, E_JAL);
    alu_ins(OP_R, E_EXECR);

    // beq taken then not taken
    fetch();
    cyc(E_DECODE, OP_B, 1'b1, 1'b0);
    cyc(E_BEQ1, OP_B, 1'b1, 1'b0);
    ec++;
    fetch();
    cyc(E_DECODE, OP_B, 1'b0, 1'b0);
    cyc(E_BEQ0, OP_B, 1'b0, 1'b1);
    ec++;

    alu_ins(OP_I, E_EXECI);
    alu_ins(OP_LUI, E_LUI);
    alu_ins(OP_AUIPC, E_AUIPC);

    fetch();
    cyc(E_DECODE, OP_JALR, 1'b0, 1'b1);
    cyc(E_JALR, OP_JALR, 1'b0, 1'b0);
    cyc(E_JALRWB, OP_JALR, 1'b0, 1'b1);
    ec++;

    // illegal opcode returns to FETCH without retiring
    fetch();
    cyc(E_DECILL, 7'h7F, 1'b0, 1'b0);
    cyc(E_FETCH0, 7'h7F, 1'b0, 1'b0);
    cyc(E_FETCH0, 7'h7F, 1'b0, 1'b0);

    // stores: counter runs 8 -> 15 -> wraps to 0
    sw_ins(1);
    for (int k = 0; k < 7; k++) sw_ins(0);
    cyc(E_FETCH0, 7'h00, 1'b0, 1'b0);
    @(negedge clk); #1 rst_h_ni = 1'b1;

    // ILLEGAL_HALT=1 instance: sticky HALT until reset
    chk_h = 1'b1;
    ec    = 4'd0;
    fetch();
    cyc(E_DECILL, 7'h7F, 1'b0, 1'b1);
    repeat (3) cyc(E_HALT, 7'h7F, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(7'h00, 1'b0, 1'b0);
    rst_h_ni = 1'b0;
    push(E_FETCH0);
    @(negedge clk); #1;
    done = 1'b1;
  end

endmodule
